insn_encoder: RTL
=================

# insn_encoder

Sequential instruction encoder and instruction-memory loader for the 5-bit-opcode, 32-bit ISA. It accepts one instruction per handshake as a one-hot type vector plus register, immediate and target fields. The bit order of the type vector matches the decoder's is_* outputs. The block packs each instruction into a 32-bit word and writes it into instruction memory at consecutive addresses. It sits between the boot/test loader and the imem write port, ahead of fetch.

## Interface
- ADDR_W, 12: imem address width.
- DEPTH, 4096: words writable before full; DEPTH ≤ 2^ADDR_W.
- clock  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- rewind  in  1  sync: address counter to 0, clears full; err untouched.
- in_valid  in  1  instruction fields valid.
- in_ready  out  1  = ~full & ~rewind.
- in_type  in  11  one-hot {setx,bex,blt,jr,jal,bne,j,lw,sw,ri,r} (bit0 = r).
- in_rd, in_rs, in_rt, in_shamt, in_aluop  in  5 each  register/shift/ALU fields.
- in_imm  in  32  signed immediate.
- in_target  in  32  unsigned jump target.
- imem_we  out  1  write strobe.
- imem_addr  out  ADDR_W  write address.
- imem_data  out  32  encoded word.
- count  out  ADDR_W+1  words written since reset/rewind.
- full  out  1  count == DEPTH.
- err  out  1  sticky: rejected instruction seen.

## Operation
- Accept = in_valid & in_ready. Fields are encoded combinationally and registered on accept.
- Opcodes: r 00000, j 00001, bne 00010, jal 00011, jr 00100, ri 00101, blt 00110, sw 00111, lw 01000, setx 10101, bex 10110.
- R-format (r): [31:27] op, [26:22] rd, [21:17] rs, [16:12] rt, [11:7] shamt, [6:2] aluop, [1:0] 0.
- I-format (ri, sw, lw, bne, blt): op, rd, rs, [16:0] = in_imm[16:0].
- JI-format (j, jal, setx, bex): op, [26:0] = in_target[26:0].
- JII-format (jr): op, [26:22] rd, [21:0] 0.
- Address counter: wr_ptr increments once per written word; imem_addr = wr_ptr before the increment.
- count follows wr_ptr. full is asserted when count reaches DEPTH, and no further writes occur.
- No wrap-around: at full, in_ready is low until rewind or reset.
- Rejected instruction (checking build only): no write, no pointer change, err set. The handshake still completes, so the source is never stalled by errors.
- rewind and an in_valid in the same cycle: rewind wins. in_ready is low, so nothing is accepted.
- A write already registered in the rewind cycle still issues at its old address on the next cycle. The counter then restarts from 0.
- reset mid-stream: the pending write is dropped and all state is cleared.

## Timing
- Reset values: imem_we 0, imem_addr 0, imem_data 0, count 0, full 0, err 0. in_ready = 1 once reset is low.
- Latency: accept at edge N → imem_we=1 with addr/data during cycle N+1, for one cycle per word.
- Throughput: 1 word per cycle while not full. Back-to-back accepts give consecutive addresses with no bubbles.
- full asserts in the cycle after the DEPTH-th accept. That accept's write still issues.
- err asserts in the cycle after the rejecting accept and stays high until reset.

## Configuration
- INSN_ENC_CHECK_EN defined, an accepted instruction is rejected when any of these hold:
  - in_type is not exactly one-hot.
  - I-format in_imm is outside [-65536, 65535].
  - JI-format in_target is ≥ 2^27.
- INSN_ENC_CHECK_EN undefined:
  - No checks; err is tied to 0.
  - in_type is priority-decoded, lowest set bit wins; all-zero encodes as r.
  - Immediate and target are silently truncated.

## Test plan
- Reset, then accept r with rd=1, rs=2, rt=3, shamt=0, aluop=0 → cycle N+1: we=1, addr 0, data 32'h00443000; count=1.
- Back-to-back addi rd=5, rs=0, imm=-1, then lw rd=2, rs=1, imm=4 → addr 0 data 32'h2941FFFF; addr 1 data 32'h40820004; no idle cycle between writes.
- j target 27'h123 then setx target 27'h7FFFFFF → 32'h08000123 then 32'hAFFFFFFF.
- With DEPTH=4: 5 valid instructions → 4 writes at addrs 0-3; full=1 after the 4th; in_ready=0; 5th held. Then pulse rewind → full=0; 5th written at addr 0.
- Checking build: ri with imm=70000, then type=11'b0000_0000_011 → no writes, err=1 sticky, count unchanged. Then a valid sw is written at the unchanged address.
- Assert reset in the cycle after an accept → no imem_we the next cycle; count=0; outputs at reset values.

Source files
------------

// File: rtl/insn_encoder_if.sv
// rtl/insn_encoder_if.sv - instruction handshake and imem write-port bundle for insn_encoder
interface insn_encoder_if #(
  parameter int ADDR_W = 12
);
  logic              in_valid;
  logic              in_ready;
  logic [10:0]       in_type;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_shamt;
  logic [4:0]        in_aluop;
  logic [31:0]       in_imm;
  logic [31:0]       in_target;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_data;

  // Loader side: presents instructions, observes the write port
  modport master (
    output in_valid, in_type, in_rd, in_rs, in_rt, in_shamt, in_aluop, in_imm, in_target,
    input  in_ready, imem_we, imem_addr, imem_data
  );

  // Encoder side
  modport slave (
    input  in_valid, in_type, in_rd, in_rs, in_rt, in_shamt, in_aluop, in_imm, in_target,
    output in_ready, imem_we, imem_addr, imem_data
  );
endinterface

// File: rtl/insn_encoder.sv
// rtl/insn_encoder.sv - instruction encoder and imem loader; optional field checking via INSN_ENC_CHECK_EN
module insn_encoder #(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4096
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rewind,
  insn_encoder_if.slave     bus,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err
);

  typedef enum logic [1:0] {FMT_R, FMT_I, FMT_JI, FMT_JII} fmt_e;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W:0] wr_ptr;
  logic [3:0]      sel;
  logic [4:0]      opcode;
  fmt_e            fmt;
  logic [31:0]     word;
  logic            reject;
  logic            accept;

  assign bus.in_ready = ~full & ~rewind;
  assign accept       = bus.in_valid & bus.in_ready;
  assign count        = wr_ptr;

  // Pick the instruction from the lowest set type bit (all-zero means r), then pack the word
  always_comb begin
    sel = 4'd0;
    for (int i = 10; i >= 0; i--) begin
      if (bus.in_type[i]) sel = 4'(i);
    end
    opcode = 5'b00000;
    fmt    = FMT_R;
    case (sel)
      4'd1:    begin opcode = 5'b00101; fmt = FMT_I;   end  // ri
      4'd2:    begin opcode = 5'b00111; fmt = FMT_I;   end  // sw
      4'd3:    begin opcode = 5'b01000; fmt = FMT_I;   end  // lw
      4'd4:    begin opcode = 5'b00001; fmt = FMT_JI;  end  // j
      4'd5:    begin opcode = 5'b00010; fmt = FMT_I;   end  // bne
      4'd6:    begin opcode = 5'b00011; fmt = FMT_JI;  end  // jal
      4'd7:    begin opcode = 5'b00100; fmt = FMT_JII; end  // jr
      4'd8:    begin opcode = 5'b00110; fmt = FMT_I;   end  // blt
      4'd9:    begin opcode = 5'b10110; fmt = FMT_JI;  end  // bex
      4'd10:   begin opcode = 5'b10101; fmt = FMT_JI;  end  // setx
      default: begin opcode = 5'b00000; fmt = FMT_R;   end  // r
    endcase
    word = 32'd0;
    case (fmt)
      FMT_R:   word = {opcode, bus.in_rd, bus.in_rs, bus.in_rt, bus.in_shamt, bus.in_aluop, 2'b00};
      FMT_I:   word = {opcode, bus.in_rd, bus.in_rs, bus.in_imm[16:0]};
      FMT_JI:  word = {opcode, bus.in_target[26:0]};
      FMT_JII: word = {opcode, bus.in_rd, 22'd0};
      default: word = 32'd0;
    endcase
  end

`ifdef INSN_ENC_CHECK_EN
  logic one_hot;
  logic imm_fits;
  logic target_fits;

  // Reject malformed type vectors and fields that would not survive packing
  always_comb begin
    one_hot     = (bus.in_type != 11'd0) && ((bus.in_type & (bus.in_type - 11'd1)) == 11'd0);
    // A 17-bit signed value: bits above 16 must all copy the sign bit
    imm_fits    = (bus.in_imm[31:16] == 16'h0000) || (bus.in_imm[31:16] == 16'hFFFF);
    target_fits = (bus.in_target[31:27] == 5'd0);
    reject      = 1'b0;
    if (!one_hot)                        reject = 1'b1;
    else if (fmt == FMT_I  && !imm_fits)    reject = 1'b1;
    else if (fmt == FMT_JI && !target_fits) reject = 1'b1;
  end
`else
  logic unused_high_bits;
  assign unused_high_bits = ^{bus.in_imm[31:17], bus.in_target[31:27]};
  assign reject = 1'b0;
`endif

  // Register the encoded word on accept and advance the write pointer; rewind restarts it
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr        <= '0;
      full          <= 1'b0;
      err           <= 1'b0;
      bus.imem_we   <= 1'b0;
      bus.imem_addr <= '0;
      bus.imem_data <= 32'd0;
    end else begin
      bus.imem_we <= 1'b0;
      if (rewind) begin
        wr_ptr <= '0;
        full   <= 1'b0;
      end else if (accept) begin
        if (reject) begin
          err <= 1'b1;
        end else begin
          bus.imem_we   <= 1'b1;
          bus.imem_addr <= wr_ptr[ADDR_W-1:0];
          bus.imem_data <= word;
          wr_ptr        <= wr_ptr + 1'b1;
          full          <= ((wr_ptr + 1'b1) == DEPTH_C);
        end
      end
    end
  end

endmodule
